// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, loader state encoding and memory word layout
package fft_pkg;

  localparam int FFT_N     = 1024;
  localparam int FFT_LOG2N = 10;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_FLUSH = 2'd1,
    LD_START = 2'd2,
    LD_BUSY  = 2'd3
  } loader_state_e;

  // Memory word = two DATA_W fields; index counts in DATA_W units from the LSB.
  localparam int WORD_REAL_FIELD = 0;
  localparam int WORD_IMAG_FIELD = 1;

endpackage

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational bit reversal, in_bits[k] -> out_bits[W-1-k]
module bit_reverse #(
  parameter int W = 10
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);

  always_comb begin
    out_bits = '0;
    for (int k = 0; k < W; k++) begin
      out_bits[W-1-k] = in_bits[k];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - streams real samples into bank 0 in bit-reversed order
// and hands each full frame to the address generation unit.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = FFT_LOG2N,
  parameter int OVF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                mem_we_o,
  output logic [N_LOG2-1:0]   mem_addr_o,
  output logic [2*DATA_W-1:0] mem_wdata_o,
  output logic                start_o,
  input  logic                fft_done_i,
  output logic                busy_o,
  output logic [OVF_W-1:0]    ovf_cnt_o,
  input  logic                clr_ovf_i
);

  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  loader_state_e       state;
  logic [N_LOG2-1:0]   n;
  logic [N_LOG2-1:0]   n_rev;
  logic [2*DATA_W-1:0] word;
  logic                accept;
  logic                drop;

  bit_reverse #(.W(N_LOG2)) u_bit_reverse (
    .in_bits  (n),
    .out_bits (n_rev)
  );

  assign s_ready_o = (state == LD_LOAD);
  assign accept    = s_valid_i & s_ready_o;
  assign drop      = s_valid_i & ~s_ready_o;

  always_comb begin
    word = '0;
    word[WORD_IMAG_FIELD*DATA_W +: DATA_W] = '0;
    word[WORD_REAL_FIELD*DATA_W +: DATA_W] = s_data_i;
  end

  // The last write lands in FLUSH, so start_o always trails it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LD_LOAD;
      n           <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      mem_we_o <= accept;
      start_o  <= 1'b0;
      case (state)
        LD_LOAD: begin
          if (accept) begin
            mem_addr_o  <= n_rev;
            mem_wdata_o <= word;
            n           <= n + 1'b1;
            if (&n) state <= LD_FLUSH;
          end
        end
        LD_FLUSH: begin
          state   <= LD_START;
          start_o <= 1'b1;
        end
        LD_START: begin
          state  <= LD_BUSY;
          busy_o <= 1'b1;
        end
        LD_BUSY: begin
          if (fft_done_i) begin
            state  <= LD_LOAD;
            busy_o <= 1'b0;
          end
        end
        default: state <= LD_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_o <= '0;
    end else if (clr_ovf_i) begin
      ovf_cnt_o <= drop ? OVF_W'(1) : '0;
    end else if (drop && ovf_cnt_o != OVF_MAX) begin
      ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - randomized bench for fft_input_loader against a frame-level reference model
module tb_fft_input_loader;

  localparam int DW = 16;
  localparam int NL = 10;
  localparam int OW = 16;
  localparam int N  = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_data_i;
  logic            s_valid_i;
  logic            s_ready_o;
  logic            mem_we_o;
  logic [NL-1:0]   mem_addr_o;
  logic [2*DW-1:0] mem_wdata_o;
  logic            start_o;
  logic            fft_done_i;
  logic            busy_o;
  logic [OW-1:0]   ovf_cnt_o;
  logic            clr_ovf_i;

  fft_input_loader #(.DATA_W(DW), .N_LOG2(NL), .OVF_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .start_o     (start_o),
    .fft_done_i  (fft_done_i),
    .busy_o      (busy_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .clr_ovf_i   (clr_ovf_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: samples in current frame, handoff stage, pending write queue.
  int  m_n;
  int  m_stage;   // 0 loading/busy, 1 flush cycle, 2 start cycle
  bit  m_busy;
  bit  m_we;
  int  m_ovf;
  int  q_addr[$];
  int  q_data[$];

  int          start_seen;
  int          wr_log[$];
  int          ramp_order[$];
  logic [31:0] tmem [N];
  int          sent [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int k = 0; k < NL; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_stage = 0; m_busy = 0; m_we = 0; m_ovf = 0;
    q_addr.delete(); q_data.delete();
  endtask

  task automatic tick();
    bit rdy, acc, drop;
    int a, d;
    @(negedge clk);
    rdy = (m_stage == 0) && !m_busy;
    check_eq("ready", 64'(s_ready_o), 64'(rdy));
    check_eq("we", 64'(mem_we_o), 64'(m_we));
    if (m_we && q_addr.size() > 0) begin
      a = q_addr.pop_front();
      d = q_data.pop_front();
      check_eq("addr", 64'(mem_addr_o), 64'(a));
      check_eq("wdata", 64'(mem_wdata_o), 64'(d));
    end
    check_eq("start", 64'(start_o), 64'(m_stage == 2));
    check_eq("busy", 64'(busy_o), 64'(m_busy));
    check_eq("ovf", 64'(ovf_cnt_o), 64'(m_ovf));
    if (mem_we_o === 1'b1) begin
      tmem[mem_addr_o] = mem_wdata_o;
      wr_log.push_back(int'(mem_addr_o));
    end
    if (start_o === 1'b1) start_seen++;
    acc  = s_valid_i && rdy;
    drop = s_valid_i && !rdy;
    if (rst) begin
      model_reset();
    end else begin
      if (clr_ovf_i) m_ovf = drop ? 1 : 0;
      else if (drop && m_ovf < 65535) m_ovf++;
      m_we = acc;
      if (m_stage == 2) begin
        m_stage = 0;
        m_busy  = 1;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_busy && fft_done_i) begin
        m_busy = 0;
      end
      if (acc) begin
        q_addr.push_back(brev(m_n));
        q_data.push_back(int'(s_data_i));
        sent[m_n] = int'(s_data_i);
        if (m_n == N - 1) begin
          m_n = 0;
          m_stage = 1;
        end else begin
          m_n++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < N; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = DW'(i);
      tick();
    end
    s_valid_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_done(input bit with_valid);
    fft_done_i = 1'b1;
    s_valid_i  = with_valid;
    tick();
    fft_done_i = 1'b0;
    s_valid_i  = 1'b0;
    check_eq("ready_after_done", 64'(s_ready_o), 64'd1);
  endtask

  task automatic compare_order(input string tag);
    int bad = 0;
    if (wr_log.size() != ramp_order.size()) bad = 1;
    else for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != ramp_order[i]) bad++;
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int cyc, bad;
    bit seen [N];
    rst = 1'b1; s_valid_i = 1'b0; s_data_i = '0; fft_done_i = 1'b0; clr_ovf_i = 1'b0;
    model_reset();
    start_seen = 0;
    @(posedge clk); #1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Continuous ramp frame
    wr_log.delete(); start_seen = 0;
    ramp_frame();
    check_eq("ramp_start_once", 64'(start_seen), 64'd1);
    check_eq("ramp_writes", 64'(wr_log.size()), 64'(N));
    check_eq("mem512", 64'(tmem[512]), 64'd1);
    check_eq("mem1", 64'(tmem[1]), 64'd512);
    check_eq("mem768", 64'(tmem[768]), 64'd3);
    ramp_order = wr_log;

    // Drops while busy, clear, saturation
    for (int i = 0; i < 100; i++) begin
      s_valid_i = 1'b1; s_data_i = DW'($urandom); tick();
    end
    check_eq("ovf100", 64'(ovf_cnt_o), 64'd100);
    clr_ovf_i = 1'b1; tick();
    clr_ovf_i = 1'b0; s_valid_i = 1'b0; tick();
    check_eq("ovf_clr_drop", 64'(ovf_cnt_o), 64'd1);
    s_valid_i = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check_eq("ovf_sat", 64'(ovf_cnt_o), 64'd65535);
    s_valid_i = 1'b0;
    clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0; tick();
    check_eq("ovf_clr", 64'(ovf_cnt_o), 64'd0);
    pulse_done(1'b1);
    check_eq("done_drop", 64'(ovf_cnt_o), 64'd1);

    // Done in LOAD is ignored
    for (int i = 0; i < 4; i++) begin
      fft_done_i = i[0]; tick();
    end
    fft_done_i = 1'b0;
    check_eq("done_load_ready", 64'(s_ready_o), 64'd1);

    // Random 30% valid frame
    wr_log.delete(); start_seen = 0;
    cyc = 0;
    while (cyc < 20000 && m_stage == 0 && !m_busy) begin
      s_valid_i = ($urandom_range(99) < 30);
      s_data_i  = DW'($urandom);
      tick();
      cyc++;
    end
    check_eq("rand_frame_bound", 64'(cyc < 20000), 64'd1);
    s_valid_i = 1'b0;
    repeat (3) tick();
    check_eq("rand_writes", 64'(wr_log.size()), 64'(N));
    bad = 0;
    foreach (seen[i]) seen[i] = 0;
    foreach (wr_log[i]) begin
      if (seen[wr_log[i]]) bad++;
      seen[wr_log[i]] = 1;
    end
    check_eq("rand_no_dup", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < N; i++) if (tmem[brev(i)] != 32'(sent[i])) bad++;
    check_eq("rand_content", 64'(bad), 64'd0);
    check_eq("rand_start_once", 64'(start_seen), 64'd1);
    pulse_done(1'b0);

    // Reset after 300 accepts
    for (int i = 0; i < 300; i++) begin
      s_valid_i = 1'b1; s_data_i = DW'($urandom); tick();
    end
    s_valid_i = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; s_valid_i = 1'b0;
    check_eq("rst_ready", 64'(s_ready_o), 64'd1);
    check_eq("rst_we", 64'(mem_we_o), 64'd0);
    check_eq("rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_start", 64'(start_o), 64'd0);
    check_eq("rst_ovf", 64'(ovf_cnt_o), 64'd0);
    wr_log.delete(); start_seen = 0;
    s_valid_i = 1'b1; s_data_i = 16'h1234; tick();
    s_valid_i = 1'b0; tick();
    check_eq("post_rst_addr0", 64'(wr_log.size() > 0 ? wr_log[0] : -1), 64'd0);
    for (int i = 1; i < N - 1; i++) begin
      s_valid_i = 1'b1; s_data_i = DW'(i); tick();
    end
    s_valid_i = 1'b0; repeat (3) tick();
    check_eq("no_early_start", 64'(start_seen), 64'd0);
    s_valid_i = 1'b1; s_data_i = 16'hbeef; tick();
    s_valid_i = 1'b0; repeat (3) tick();
    check_eq("start_after_1024", 64'(start_seen), 64'd1);
    compare_order("order_after_rst");
    repeat (5) tick();
    pulse_done(1'b0);

    // Back-to-back frames
    wr_log.delete(); ramp_frame();
    compare_order("order_frame_a");
    repeat (10) begin s_valid_i = 1'b1; tick(); end
    s_valid_i = 1'b0;
    check_eq("busy_no_write", 64'(wr_log.size()), 64'(N));
    pulse_done(1'b0);
    wr_log.delete(); ramp_frame();
    compare_order("order_frame_b");
    pulse_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Streaming front end of the 1024-point radix-2 FFT. Accepts real-valued samples over a valid/ready handshake and writes each one into data memory bank 0 at the bit-reversed sample index, with the imaginary part zero. After 1024 samples, raises a one-cycle start pulse for the address generation unit. Refuses input while the transform runs and counts samples the source pushed during that window.

## Interface
- `DATA_W`, 16: sample width, two's complement; memory word is 2*DATA_W.
- `N_LOG2`, 10: log2 of the frame length; the frame is 1024 samples.
- `OVF_W`, 16: width of the dropped-sample counter.

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_data_i`, in, DATA_W: input sample.
- `s_valid_i`, in, 1: source has a sample.
- `s_ready_o`, out, 1: loader accepts a sample this cycle.
- `mem_we_o`, out, 1: write strobe to bank 0.
- `mem_addr_o`, out, N_LOG2: write address.
- `mem_wdata_o`, out, 2*DATA_W: {imag = 0, real = sample}; real is in the LSBs.
- `start_o`, out, 1: one-cycle pulse to the address generation unit.
- `fft_done_i`, in, 1: one-cycle pulse; the transform has finished and bank 0 is free.
- `busy_o`, out, 1: a frame is handed off and the FFT has not completed.
- `ovf_cnt_o`, out, OVF_W: dropped-sample count; saturates.
- `clr_ovf_i`, in, 1: clears `ovf_cnt_o`.

## Operation
- States:
  - LOAD: reset state; `s_ready_o` = 1.
  - FLUSH: one cycle; last write in flight.
  - START: one cycle; `start_o` = 1.
  - BUSY: `busy_o` = 1; `s_ready_o` = 0.
- Accept: a sample is taken when `s_valid_i` and `s_ready_o` are both 1.
- Sample counter `n` is N_LOG2 bits wide and starts at 0.
  - On each accept, the loader registers a write of sample n to address bitrev(n), where bit k of the address equals bit N_LOG2-1-k of n.
  - `n` then increments.
  - Example: n=1 goes to address 512; n=3 goes to address 768.
- Accepting n = 1023:
  - `n` wraps to 0.
  - `s_ready_o` drops in the next cycle, which is the FLUSH cycle.
  - The FSM moves LOAD -> FLUSH -> START -> BUSY.
- BUSY -> LOAD on `fft_done_i`.
- `fft_done_i` outside BUSY is ignored.
- Dropped samples: `s_valid_i` = 1 while `s_ready_o` = 0 counts one drop per cycle.
  - `ovf_cnt_o` increments by one per drop and saturates at 2^OVF_W - 1.
  - `clr_ovf_i` with a drop in the same cycle sets the count to 1.
  - `clr_ovf_i` alone sets the count to 0.
- Source stalls: `s_valid_i` low in LOAD holds `n`; a partial frame waits indefinitely.
- Reset at any time, including mid-frame:
  - `n` = 0, state = LOAD, `ovf_cnt_o` = 0.
  - The partial frame is discarded; written words stay in memory and are overwritten later.
- Reset values of outputs: `s_ready_o` = 1 (state LOAD); `mem_we_o`, `start_o`, `busy_o` = 0; `mem_addr_o`, `mem_wdata_o`, `ovf_cnt_o` = 0.

## Timing
- Accept-to-write latency is 1 cycle: accept in cycle k gives `mem_we_o`, address and data valid in cycle k+1, for one cycle.
- Throughput is one sample per cycle; a full frame takes at least 1024 cycles.
- Last accept in cycle k:
  - Last write in k+1 (FLUSH).
  - `start_o` in k+2.
  - `busy_o` from k+3.
- `start_o` is always at least one cycle after the final write strobe.
- `fft_done_i` in cycle m gives `busy_o` = 0 and `s_ready_o` = 1 in m+1.
- `fft_done_i` together with `s_valid_i` in cycle m: that sample counts as dropped; acceptance resumes in m+1.
- All outputs are registered except `s_ready_o`, which is decoded from the state register.

## Structure
- `fft_pkg` holds:
  - `FFT_N` = 1024 and `FFT_LOG2N` = 10;
  - the loader state encoding (LOAD, FLUSH, START, BUSY);
  - the memory word layout constants (real field in the LSBs, imag field in the MSBs).
- Sub-module `bit_reverse` is combinational, with parameter W, and maps in[k] -> out[W-1-k]. The address generation unit and the output reader reuse it.

## Test plan
- Continuous ramp, samples 0..1023 with `s_valid_i` always high:
  - writes go to bitrev(n) with data {0, n};
  - address 512 holds 1 and address 1 holds 512;
  - `start_o` pulses exactly once, 2 cycles after the last accept.
- Random `s_valid_i`, 30% duty:
  - 1024 writes with no duplicate addresses;
  - the sample order is preserved.
- Source keeps pushing during BUSY for 100 cycles:
  - `ovf_cnt_o` = 100;
  - `clr_ovf_i` asserted with a drop gives 1;
  - forcing the count to 65535 keeps it at 65535 on further drops.
- Reset after 300 accepts:
  - all outputs return to their reset values;
  - the next sample is written to address 0;
  - `start_o` fires only after 1024 further accepts.
- `fft_done_i` pulsed during LOAD:
  - no state change;
  - a done pulse in BUSY raises `s_ready_o` the next cycle.
- Two back-to-back frames:
  - the second frame has identical address order;
  - no write occurs between `start_o` and `fft_done_i`.
